// File: rtl/strobe_timing_gen.sv
// Detector integration timing: ms tick, integ_start pulse, continuous and single lamp strobes; optional CONT_STROBE_RESYNC_EN.
// Latency: outputs are registered; integ_start is asserted 1 cycle after run is first sampled high, and outputs clear 1 cycle after run drops.
// Backpressure: none. The block free-runs while run=1, and cfg_* is sampled only at integration-period start.
module strobe_timing_gen #(
    parameter int TICK_DIV = 48000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        run,
    input  logic [15:0] cfg_countbase,
    input  logic [15:0] cfg_strbcount,
    input  logic [15:0] cfg_intclock,
    input  logic [15:0] cfg_sslowdelay,
    input  logic [15:0] cfg_sshighdelay,
    input  logic [15:0] cfg_lampenable,
    output logic        ms_tick,
    output logic        integ_start,
    output logic [15:0] int_ms_cnt,
    output logic        cont_strobe,
    output logic        single_strobe
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tick_cnt, tick_nxt;
    logic [15:0]   ms_cnt, ms_nxt;
    logic [15:0]   base_cnt, base_nxt;
    logic [15:0]   int_sh, hi_sh, lo_sh, cb_sh, sc_sh;
    logic [15:0]   int_nxt, hi_nxt, lo_nxt, cb_nxt, sc_nxt;
    logic          en_sh, en_nxt;
    logic          ms_tick_nxt, integ_start_nxt, cont_nxt, single_nxt;
    logic          tick_wrap, period_end, load_sh, active;
    logic          unused_lamp_bits;

    assign unused_lamp_bits = ^cfg_lampenable[15:1];
    assign int_ms_cnt       = ms_cnt;

    always_comb begin
        state_nxt       = state;
        tick_nxt        = '0;
        ms_nxt          = '0;
        base_nxt        = '0;
        ms_tick_nxt     = 1'b0;
        integ_start_nxt = 1'b0;

        tick_wrap  = (tick_cnt == TICK_LAST);
        // int_sh is never 0 while running, so the subtraction cannot wrap
        period_end = tick_wrap && (ms_cnt >= int_sh - 16'd1);
        load_sh    = ((state == ST_IDLE) && run) ||
                     ((state == ST_RUN) && run && period_end);

        int_nxt = load_sh ? ((cfg_intclock == 16'd0) ? 16'd1 : cfg_intclock) : int_sh;
        hi_nxt  = load_sh ? cfg_sshighdelay  : hi_sh;
        lo_nxt  = load_sh ? cfg_sslowdelay   : lo_sh;
        cb_nxt  = load_sh ? cfg_countbase    : cb_sh;
        sc_nxt  = load_sh ? cfg_strbcount    : sc_sh;
        en_nxt  = load_sh ? cfg_lampenable[0] : en_sh;

        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nxt       = ST_RUN;
                    integ_start_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_nxt = ST_IDLE;
                end else begin
                    tick_nxt        = tick_wrap ? '0 : tick_cnt + 1'b1;
                    ms_tick_nxt     = tick_wrap;
                    integ_start_nxt = period_end;
                    if (period_end)
                        ms_nxt = '0;
                    else if (tick_wrap)
                        ms_nxt = ms_cnt + 16'd1;
                    else
                        ms_nxt = ms_cnt;

                    // >= rather than == so a shrunken period base never overruns
                    if (cb_nxt == 16'd0)
                        base_nxt = '0;
`ifdef CONT_STROBE_RESYNC_EN
                    else if (period_end)
                        base_nxt = '0;
`endif
                    else if (base_cnt >= cb_nxt - 16'd1)
                        base_nxt = '0;
                    else
                        base_nxt = base_cnt + 16'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        active     = (state_nxt == ST_RUN);
        single_nxt = active && en_nxt && (ms_nxt >= hi_nxt) && (ms_nxt < lo_nxt);
        cont_nxt   = active && en_nxt && (cb_nxt != 16'd0) && (base_nxt < sc_nxt);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= ST_IDLE;
            tick_cnt      <= '0;
            ms_cnt        <= '0;
            base_cnt      <= '0;
            int_sh        <= '0;
            hi_sh         <= '0;
            lo_sh         <= '0;
            cb_sh         <= '0;
            sc_sh         <= '0;
            en_sh         <= 1'b0;
            ms_tick       <= 1'b0;
            integ_start   <= 1'b0;
            cont_strobe   <= 1'b0;
            single_strobe <= 1'b0;
        end else begin
            state         <= state_nxt;
            tick_cnt      <= tick_nxt;
            ms_cnt        <= ms_nxt;
            base_cnt      <= base_nxt;
            int_sh        <= int_nxt;
            hi_sh         <= hi_nxt;
            lo_sh         <= lo_nxt;
            cb_sh         <= cb_nxt;
            sc_sh         <= sc_nxt;
            en_sh         <= en_nxt;
            ms_tick       <= ms_tick_nxt;
            integ_start   <= integ_start_nxt;
            cont_strobe   <= cont_nxt;
            single_strobe <= single_nxt;
        end
    end

endmodule
